// File: rtl/ycr1_tcm_dmem_port.sv
//-----------------------------------------------------------------------------
// ycr1_tcm_dmem_port
//
// Initiator-side controller for port B of the TCM dual-port RAM. It takes
// core data-memory requests (req/ack handshake plus a one-cycle-later
// response), checks width, alignment and address range, steers byte lanes
// onto the synchronous memory port, and returns aligned, zero-extended read
// data in the cycle after acceptance. After reset it can optionally zero-fill
// the whole TCM before it accepts any request.
//
// Parameters:
//   YCR1_SIZE     TCM size in bytes (power of two)
//   YCR1_TCM_BASE base address of the TCM window (aligned to YCR1_SIZE)
//   YCR1_INIT_EN  1 = zero-fill after reset, 0 = accept requests at once
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   dmem_req         request valid
//   dmem_cmd         0 = read, 1 = write
//   dmem_width       00 byte, 01 half, 10 word, 11 illegal
//   dmem_addr        byte address
//   dmem_wdata       right-justified write data
//   dmem_req_ack     request accepted this cycle (combinational)
//   dmem_rdata       read data, valid with dmem_resp = RDY after a read
//   dmem_resp        00 IDLE, 01 RDY, 10 ER
//   init_done        zero-fill complete
//   mem_renb/wenb    memory port B read / write enable
//   mem_webb         memory port B byte write enables
//   mem_addrb        memory port B word address
//   mem_datab        memory port B write data
//   mem_qb           memory port B read data (one-cycle synchronous)
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module ycr1_tcm_dmem_port #(
  parameter logic [31:0] YCR1_SIZE     = 32'h00010000,
  parameter logic [31:0] YCR1_TCM_BASE = 32'hF0000000,
  parameter bit          YCR1_INIT_EN  = 1'b1,
  localparam int         AW            = $clog2(YCR1_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dmem_req,
  input  logic          dmem_cmd,
  input  logic [1:0]    dmem_width,
  input  logic [31:0]   dmem_addr,
  input  logic [31:0]   dmem_wdata,
  output logic          dmem_req_ack,
  output logic [31:0]   dmem_rdata,
  output logic [1:0]    dmem_resp,
  output logic          init_done,
  output logic          mem_renb,
  output logic          mem_wenb,
  output logic [3:0]    mem_webb,
  output logic [AW-3:0] mem_addrb,
  output logic [31:0]   mem_datab,
  input  logic [31:0]   mem_qb
);

  localparam logic [1:0] RESP_IDLE = 2'b00;
  localparam logic [1:0] RESP_RDY  = 2'b01;
  localparam logic [1:0] RESP_ER   = 2'b10;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_ILL  = 2'b11;

  // Last word index of the fill sweep.
  localparam logic [AW-3:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam state_t ST_RESET = YCR1_INIT_EN ? ST_INIT : ST_IDLE;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [AW-3:0]   r_cnt;
  logic            r_init_done;
  logic            r_err;
  logic            r_cmd;
  logic [1:0]      r_width;
  logic [1:0]      r_off;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t          w_state_next;
  logic [AW-3:0]   w_cnt_next;
  logic            w_init_done_next;

  logic            w_run;
  logic            w_in_init;
  logic            w_ack;
  logic            w_accept;
  logic            w_err_width;
  logic            w_err_align;
  logic            w_err_range;
  logic            w_err;
  logic            w_go;
  logic            w_rd;
  logic            w_wr;
  logic [3:0]      w_lane_sel;
  logic [31:0]     w_wdata_rep;
  logic [31:0]     w_qb_shift;

  // The combinational outputs are forced to their idle values while reset is
  // held, so every output sits at its reset value during rst, not just the
  // registered ones.
  assign w_run     = ~rst;
  assign w_in_init = w_run & (r_state == ST_INIT);

  // Acknowledge is a pure function of state: the core may present a request
  // every cycle outside INIT and it is taken immediately.
  assign w_ack    = w_run & (r_state != ST_INIT);
  assign w_accept = w_ack & dmem_req;

  // ---------------------------------------------------------------------------
  // Request checking
  // ---------------------------------------------------------------------------
  assign w_err_width = (dmem_width == W_ILL);
  assign w_err_align = ((dmem_width == W_HALF) & dmem_addr[0]) |
                       ((dmem_width == W_WORD) & (dmem_addr[1:0] != 2'b00));
  assign w_err_range = (dmem_addr[31:AW] != YCR1_TCM_BASE[31:AW]);
  assign w_err       = w_err_width | w_err_align | w_err_range;

  // A request only reaches the memory if it passed every check.
  assign w_go = w_accept & ~w_err;
  assign w_rd = w_go & ~dmem_cmd;
  assign w_wr = w_go &  dmem_cmd;

  // ---------------------------------------------------------------------------
  // Byte-lane steering: lane gi is written for a word, for a half whose
  // address selects the lane pair containing gi, or for a byte at offset gi.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign w_lane_sel[gi] = (dmem_width == W_WORD) |
                              ((dmem_width == W_HALF) & (dmem_addr[1] == LANE[1])) |
                              ((dmem_width == W_BYTE) & (dmem_addr[1:0] == LANE));
    end
  endgenerate

  // Write data is replicated across the word so whichever lanes are enabled
  // carry the right bytes without a barrel shifter.
  always_comb begin
    w_wdata_rep = dmem_wdata;
    case (dmem_width)
      W_BYTE:  w_wdata_rep = {4{dmem_wdata[7:0]}};
      W_HALF:  w_wdata_rep = {2{dmem_wdata[15:0]}};
      default: w_wdata_rep = dmem_wdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory port drive: INIT sweep has priority; otherwise only a checked,
  // accepted request produces any enable.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_renb  = 1'b0;
    mem_wenb  = 1'b0;
    mem_webb  = 4'h0;
    mem_addrb = '0;
    mem_datab = 32'h0;
    if (w_in_init) begin
      mem_wenb  = 1'b1;
      mem_webb  = 4'hF;
      mem_addrb = r_cnt;
    end else if (w_go) begin
      mem_addrb = dmem_addr[AW-1:2];
      if (w_rd) begin
        mem_renb = 1'b1;
      end
      if (w_wr) begin
        mem_wenb  = 1'b1;
        mem_webb  = w_lane_sel;
        mem_datab = w_wdata_rep;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_init_done_next = r_init_done;
    case (r_state)
      ST_INIT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_next     = ST_IDLE;
          w_cnt_next       = '0;
          w_init_done_next = 1'b1;
        end
      end
      ST_IDLE, ST_RESP: begin
        w_state_next = w_accept ? ST_RESP : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RESET;
      r_cnt       <= '0;
      r_init_done <= ~YCR1_INIT_EN;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_init_done <= w_init_done_next;
    end
  end

  // Attributes of the accepted request, needed to build its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err   <= 1'b0;
      r_cmd   <= 1'b0;
      r_width <= 2'b00;
      r_off   <= 2'b00;
    end else if (w_accept) begin
      r_err   <= w_err;
      r_cmd   <= dmem_cmd;
      r_width <= dmem_width;
      r_off   <= dmem_addr[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Response: mem_qb already holds the word read at the acceptance edge, so
  // alignment is applied combinationally in the RESP cycle.
  // ---------------------------------------------------------------------------
  assign w_qb_shift = mem_qb >> {r_off, 3'b000};

  always_comb begin
    dmem_resp  = RESP_IDLE;
    dmem_rdata = 32'h0;
    if (w_run && (r_state == ST_RESP)) begin
      if (r_err) begin
        dmem_resp = RESP_ER;
      end else begin
        dmem_resp = RESP_RDY;
        if (!r_cmd) begin
          case (r_width)
            W_BYTE:  dmem_rdata = {24'h0, w_qb_shift[7:0]};
            W_HALF:  dmem_rdata = {16'h0, w_qb_shift[15:0]};
            default: dmem_rdata = w_qb_shift;
          endcase
        end
      end
    end
  end

  assign dmem_req_ack = w_ack;
  assign init_done    = r_init_done;

endmodule
